// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer states,
// requester-count limit and the width of a requester index.
package dmem_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from last+1,
// wrapping modulo N_REQ, and returns the first active requester.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic found;

  // Walk the priority ring starting just after the previous winner
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (((int'(last) + off) % N_REQ) == j)) begin
          winner = IDX_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between N_REQ requesters using a round-robin
// grant and an IDLE -> ACCESS -> RESP sequencer with hold-until-ack handshakes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_din,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_dout
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q;
  logic [IDX_W-1:0]  win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              grant;
  logic              capture;
  logic              finish;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // Route the chosen requester's command fields toward the latches
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer state register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state strobes; arbitration only happens in IDLE
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted transaction so it completes even if req drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      win_q   <= pick_idx;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Remember the last served port; reset value makes port 0 win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N_REQ - 1);
    end else if (finish) begin
      last_q <= win_q;
    end
  end

  // Capture memory output at the end of ACCESS; held until the next access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= mem_dout;
    end
  end

  // Decode outputs from state so reset clears them without waiting for a clock
  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = (state_q == RESP) && (win_q == IDX_W'(i));
    end
    busy     = (state_q != IDLE);
    mem_we   = (state_q == ACCESS) && we_q;
    mem_addr = addr_q;
    mem_din  = wdata_q;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with four requesters and a local
// 64x32 memory (async read, write on the falling clock edge).
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic              mem_we;
  logic [DW-1:0]     mem_dout;

  logic [DW-1:0]     mem [0:63];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  dmem_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Data memory: writes land on the falling edge
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  assign mem_dout = mem[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic setPort(input int p, input logic we, input logic [5:0] addr, input logic [31:0] wdata);
    req_we[p]               = we;
    req_addr[p*AW +: AW]    = addr;
    req_wdata[p*DW +: DW]   = wdata;
  endtask

  // One complete transaction on a single port, bounded wait for ack
  task automatic applyStimulus(input int p, input logic we, input logic [5:0] addr,
                               input logic [31:0] wdata, output int lat, output int we_cycles,
                               output logic [31:0] rd, output logic [3:0] ack_seen,
                               output logic [5:0] acc_addr);
    setPort(p, we, addr, wdata);
    req[p]    = 1'b1;
    lat       = -1;
    we_cycles = 0;
    rd        = '0;
    ack_seen  = '0;
    acc_addr  = '0;
    for (int j = 0; j < 10 && lat < 0; j++) begin
      @(posedge clk);
      #1;
      if (mem_we) we_cycles++;
      if (j == 0) acc_addr = mem_addr;
      if (ack != '0) begin
        lat      = j + 1;
        rd       = rdata;
        ack_seen = ack;
        req[p]   = 1'b0;
      end
    end
    req[p] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          we_cycles;
    logic [31:0] rd;
    logic [3:0]  ack_seen;
    logic [5:0]  acc_addr;
    logic [3:0]  exp_ack;

    vecs[0] = '{0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 6'h0A, 32'h12345678, 32'h0};
    vecs[3] = '{2, 1'b1, 6'h3F, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{3, 1'b1, 6'h00, 32'h0BADF00D, 32'h0};
    vecs[5] = '{3, 1'b0, 6'h3F, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{2, 1'b0, 6'h0A, 32'h0,        32'h12345678};
    vecs[7] = '{1, 1'b0, 6'h00, 32'h0,        32'h0BADF00D};
    vecs[8] = '{0, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};

    // Reset values while reset is held
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst ack",      32'(ack),      32'h0);
    checkOutput("rst busy",     32'(busy),     32'h0);
    checkOutput("rst mem_we",   32'(mem_we),   32'h0);
    checkOutput("rst rdata",    rdata,         32'h0);
    checkOutput("rst mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst mem_din",  mem_din,       32'h0);
    rst = 1'b0;

    // Single-port transactions from the vector table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, we_cycles, rd, ack_seen, acc_addr);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d ack", i), 32'(ack_seen), 32'(1) << vecs[i].port);
      checkOutput($sformatf("vec%0d we_cycles", i), 32'(we_cycles), 32'(vecs[i].we));
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(acc_addr), 32'(vecs[i].addr));
      if (!vecs[i].we) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end
    checkOutput("idle busy", 32'(busy), 32'h0);

    // Ports 0 and 1 write together right after reset
    doReset();
    setPort(0, 1'b1, 6'h30, 32'h0000AAAA);
    setPort(1, 1'b1, 6'h31, 32'h0000BBBB);
    req = 4'b0011;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      #1;
      exp_ack = (j == 1) ? 4'b0001 : (j == 4) ? 4'b0010 : 4'b0000;
      checkOutput($sformatf("pair cyc%0d ack", j + 1), 32'(ack), 32'(exp_ack));
      if (ack[0]) req[0] = 1'b0;
      if (ack[1]) req[1] = 1'b0;
    end
    req = '0;
    checkOutput("pair mem30", mem[6'h30], 32'h0000AAAA);
    checkOutput("pair mem31", mem[6'h31], 32'h0000BBBB);

    // Requester drops req while its write is in ACCESS
    setPort(2, 1'b1, 6'h11, 32'hCAFEF00D);
    req[2] = 1'b1;
    @(posedge clk); #1;
    checkOutput("drop busy access", 32'(busy), 32'h1);
    req[2] = 1'b0;
    @(posedge clk); #1;
    checkOutput("drop ack", 32'(ack), 32'h4);
    @(posedge clk); #1;
    checkOutput("drop idle busy", 32'(busy), 32'h0);
    checkOutput("drop idle ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
    checkOutput("drop stay idle", 32'(busy), 32'h0);
    checkOutput("drop mem11", mem[6'h11], 32'hCAFEF00D);

    // Continuous contention on all four ports after a fresh reset
    doReset();
    setPort(0, 1'b0, 6'h30, 32'h0);
    setPort(1, 1'b0, 6'h31, 32'h0);
    setPort(2, 1'b0, 6'h11, 32'h0);
    setPort(3, 1'b0, 6'h05, 32'h0);
    req = 4'hF;
    for (int j = 0; j < 36; j++) begin
      @(posedge clk);
      #1;
      exp_ack = ((j % 3) == 1) ? (4'b0001 << (((j - 1) / 3) % 4)) : 4'b0000;
      checkOutput($sformatf("rr cyc%0d ack", j + 1), 32'(ack), 32'(exp_ack));
      if (j == 34) req = '0;
    end
    req = '0;

    // Async reset in the middle of a write access
    setPort(3, 1'b1, 6'h22, 32'h11111111);
    req[3] = 1'b1;
    @(posedge clk); #1;
    checkOutput("arst mem_we before", 32'(mem_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst mem_we", 32'(mem_we), 32'h0);
    checkOutput("arst busy", 32'(busy), 32'h0);
    checkOutput("arst ack", 32'(ack), 32'h0);
    #1 rst = 1'b0;
    setPort(0, 1'b0, 6'h05, 32'h0);
    req[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      exp_ack = (j == 1) ? 4'b0001 : (j == 4) ? 4'b1000 : 4'b0000;
      checkOutput($sformatf("arst cyc%0d ack", j + 1), 32'(ack), 32'(exp_ack));
      if (j == 1) checkOutput("arst p0 rdata", rdata, 32'hDEADBEEF);
      if (ack[0]) req[0] = 1'b0;
      if (ack[3]) req[3] = 1'b0;
    end
    req = '0;

    // Same port holds req across ack and presents a new address
    setPort(1, 1'b0, 6'h05, 32'h0);
    req[1] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      #1;
      exp_ack = (j == 1 || j == 4) ? 4'b0010 : 4'b0000;
      checkOutput($sformatf("b2b cyc%0d ack", j + 1), 32'(ack), 32'(exp_ack));
      if (j == 1) begin
        checkOutput("b2b first rdata", rdata, 32'hDEADBEEF);
        setPort(1, 1'b0, 6'h0A, 32'h0);
      end
      if (j == 4) begin
        checkOutput("b2b second rdata", rdata, 32'h12345678);
        req[1] = 1'b0;
      end
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
